// File: rtl/instruction_decoder.sv
// Instruction field decoder: splits a 32-bit word into class, function, register,
// immediate and branch-offset fields, registered with a one-cycle latency.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic [2:0]  opCode,
  output logic [3:0]  functCode,
  output logic [4:0]  reg_1,
  output logic [4:0]  reg_2,
  output logic [31:0] imm,
  output logic [31:0] label,
  output logic        dec_valid
);

  logic [2:0]  op_d;
  logic [3:0]  funct_d;
  logic [4:0]  reg_1_d;
  logic [4:0]  reg_2_d;
  logic [31:0] imm_d;
  logic [31:0] label_d;

  // Every field is extracted regardless of opcode; the control unit picks what it needs.
  always_comb begin
    op_d    = instr[31:29];
    reg_1_d = instr[28:24];
    reg_2_d = instr[23:19];
    funct_d = instr[3:0];
    imm_d   = {{17{instr[18]}}, instr[18:4]};
    label_d = {{8{instr[23]}}, instr[23:0]};
  end

  // Fields load only on a valid word, so idle-cycle garbage on instr never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opCode    <= '0;
      functCode <= '0;
      reg_1     <= '0;
      reg_2     <= '0;
      imm       <= '0;
      label     <= '0;
    end else if (instr_valid) begin
      opCode    <= op_d;
      functCode <= funct_d;
      reg_1     <= reg_1_d;
      reg_2     <= reg_2_d;
      imm       <= imm_d;
      label     <= label_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= instr_valid;
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: arithmetic reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_instruction_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  opCode;
  logic [3:0]  functCode;
  logic [4:0]  reg_1;
  logic [4:0]  reg_2;
  logic [31:0] imm;
  logic [31:0] label;
  logic        dec_valid;

  int checks = 0;
  int errors = 0;

  instruction_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .opCode     (opCode),
    .functCode  (functCode),
    .reg_1      (reg_1),
    .reg_2      (reg_2),
    .imm        (imm),
    .label      (label),
    .dec_valid  (dec_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fields computed with plain integer arithmetic.
  longint unsigned m_op, m_fn, m_r1, m_r2, m_imm, m_lbl, m_dv;

  function automatic longint unsigned sext(input longint unsigned v, input int bits);
    longint signed s;
    s = longint'(v);
    if (v >= (64'd1 << (bits - 1))) s = s - longint'(64'd1 << bits);
    return longint'(s) & 64'hFFFF_FFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op = 0; m_fn = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_lbl = 0; m_dv = 0;
    end else begin
      m_dv = longint'(instr_valid);
      if (instr_valid) begin
        m_op  = longint'(instr) / (64'd1 << 29);
        m_r1  = (longint'(instr) / (64'd1 << 24)) % 32;
        m_r2  = (longint'(instr) / (64'd1 << 19)) % 32;
        m_fn  = longint'(instr) % 16;
        m_imm = sext((longint'(instr) / 16) % 32768, 15);
        m_lbl = sext(longint'(instr) % (64'd1 << 24), 24);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_opCode", 32'(opCode), m_op[31:0]);
    chk("model_functCode", 32'(functCode), m_fn[31:0]);
    chk("model_reg_1", 32'(reg_1), m_r1[31:0]);
    chk("model_reg_2", 32'(reg_2), m_r2[31:0]);
    chk("model_imm", imm, m_imm[31:0]);
    chk("model_label", label, m_lbl[31:0]);
    chk("model_dec_valid", 32'(dec_valid), m_dv[31:0]);
  end

  task automatic chk_all(input string tag, input logic [2:0] op, input logic [3:0] fn,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] im,
                         input logic [31:0] lb, input logic dv);
    chk({tag, "_opCode"}, 32'(opCode), 32'(op));
    chk({tag, "_functCode"}, 32'(functCode), 32'(fn));
    chk({tag, "_reg_1"}, 32'(reg_1), 32'(r1));
    chk({tag, "_reg_2"}, 32'(reg_2), 32'(r2));
    chk({tag, "_imm"}, imm, im);
    chk({tag, "_label"}, label, lb);
    chk({tag, "_dec_valid"}, 32'(dec_valid), 32'(dv));
  endtask

  // Present a word, let one edge capture it, return 1 time unit after that edge.
  task automatic step(input logic [31:0] w, input logic v);
    instr = w;
    instr_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 32'h0;
    instr_valid = 1'b0;
    #3;
    chk_all("reset", 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(32'h0000_0000, 1'b1);
    chk_all("zero", 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);

    step(32'h0A1D_CD73, 1'b1);
    chk_all("base", 3'd0, 4'd3, 5'd10, 5'd3, 32'hFFFF_DCD7, 32'h001D_CD73, 1'b1);

    for (int k = 1; k <= 6; k++) begin
      step(32'h0A1D_CD73 + (32'(k) << 29), 1'b1);
      chk_all($sformatf("sweep%0d", k), 3'(k), 4'd3, 5'd10, 5'd3, 32'hFFFF_DCD7,
              32'h001D_CD73, 1'b1);
    end

    step(32'hE000_0000, 1'b1);
    chk("op7", 32'(opCode), 32'd7);

    step(32'h0000_7FF0, 1'b1);
    chk("imm_max_pos", imm, 32'h0000_07FF);
    step(32'h0008_0000, 1'b1);
    chk_all("bit19", 3'd0, 4'd0, 5'd0, 5'd1, 32'h0, 32'h0008_0000, 1'b1);
    step(32'h0080_0000, 1'b1);
    chk_all("bit23", 3'd0, 4'd0, 5'd0, 5'd16, 32'h0, 32'hFF80_0000, 1'b1);

    step(32'h0A1D_CD73, 1'b1);
    step(32'hFFFF_FFFF, 1'b0);
    chk_all("hold", 3'd0, 4'd3, 5'd10, 5'd3, 32'hFFFF_DCD7, 32'h001D_CD73, 1'b0);
    step('x, 1'b0);
    chk_all("hold_x", 3'd0, 4'd3, 5'd10, 5'd3, 32'hFFFF_DCD7, 32'h001D_CD73, 1'b0);

    step(32'hCA1D_CD73, 1'b1);
    step(32'h2A1D_CD73, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    instr = 32'hFFFF_FFFF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_discard", 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_edge", 3'd7, 4'hF, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    step(32'h0000_0000, 1'b0);
    step(32'h0000_0000, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as in the rest of the codebase.
REQ-002 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port instr, input, 32 bits: instruction word to decode.
REQ-005 Port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-006 Port opCode, output, 3 bits: registered instruction class.
REQ-007 Port functCode, output, 4 bits: registered function code.
REQ-008 Port reg_1, output, 5 bits: registered first register index.
REQ-009 Port reg_2, output, 5 bits: registered second register index.
REQ-010 Port imm, output, 32 bits: registered sign-extended immediate.
REQ-011 Port label, output, 32 bits: registered sign-extended branch offset.
REQ-012 Port dec_valid, output, 1 bit: the output fields hold a freshly decoded word.

Function
REQ-013 Field extraction SHALL be: opCode = instr[31:29]; reg_1 = instr[28:24]; reg_2 = instr[23:19]; functCode = instr[3:0].
REQ-014 imm SHALL be instr[18:4] (15 bits) sign-extended to 32 bits using instr[18].
REQ-015 label SHALL be instr[23:0] (24 bits) sign-extended to 32 bits using instr[23].
REQ-016 Every field SHALL be extracted for every opcode (000-111); decoding is opcode-independent, and the downstream control unit selects which fields it uses.
REQ-017 On a rising clk edge with instr_valid=1, all field outputs SHALL load the decode of instr, and dec_valid SHALL go to 1 (latency: 1 cycle).
REQ-018 On a rising clk edge with instr_valid=0, all field outputs SHALL hold their previous values, and dec_valid SHALL go to 0.
REQ-019 Back-to-back valid words SHALL be accepted every cycle; there is no backpressure and no stall.
REQ-020 No output SHALL depend combinationally on instr or instr_valid.
REQ-021 X or Z on instr while instr_valid=0 SHALL NOT disturb the outputs.

Reset
REQ-022 While rst_n=0, opCode, functCode, reg_1, reg_2, imm, label and dec_valid SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-stream SHALL clear the outputs immediately and discard any word presented in that cycle.
REQ-024 The first edge after rst_n deasserts SHALL behave per REQ-017 and REQ-018.

Verification
REQ-025 instr=0x00000000 with valid=1 -> next cycle: all fields 0, dec_valid=1.
REQ-026 instr=0x0A1DCD73 with valid=1 -> next cycle: opCode=0, reg_1=10, reg_2=3, functCode=3, imm=0xFFFFDCD7, label=0x001DCD73.
REQ-027 Sweep instr=0x0A1DCD73 + (k<<29) for k=1..6 (e.g. 0x2A1DCD73, 0xCA1DCD73) on consecutive cycles -> opCode=k each cycle one cycle later, other fields unchanged from REQ-026.
REQ-028 Sign boundaries:
- instr=0x00007FF0 -> imm=0x000007FF.
- instr=0x00080000 -> imm=0x00000000, label=0x00080000.
- instr=0x00800000 -> label=0xFF800000.
REQ-029 Load 0x0A1DCD73, then drop valid with instr=0xFFFFFFFF -> fields hold the REQ-026 values, dec_valid=0.
REQ-030 Assert rst_n=0 between clock edges while outputs are non-zero -> all outputs 0 immediately, before the next edge.
